// File: rtl/oddr_pkg.sv
// Shared constants for the DDR output register: the legal capture-mode names.
package oddr_pkg;

    localparam string EDGE_OPPOSITE = "OPPOSITE_EDGE";
    localparam string EDGE_SAME     = "SAME_EDGE";

endpackage

// File: rtl/oddr_lane.sv
// Single-bit DDR output lane: rising-edge flop, falling-edge flop, optional
// SAME_EDGE hold flop, and a clock-selected output mux.
module oddr_lane
    import oddr_pkg::*;
#(
    parameter string DDR_CLK_EDGE = EDGE_OPPOSITE,
    parameter bit    INIT         = 1'b0
) (
    input  logic C,
    input  logic R,
    input  logic S,
    input  logic CE,
    input  logic D1,
    input  logic D2,
    output logic Q
);

    localparam bit SAME_MODE = (DDR_CLK_EDGE == EDGE_SAME);

    logic arst_s;
    logic fall_d_s;
    logic pos_r = INIT;
    logic neg_r = INIT;

    assign arst_s = R | S;

    generate
        if ((DDR_CLK_EDGE != EDGE_OPPOSITE) && (DDR_CLK_EDGE != EDGE_SAME)) begin : g_bad_edge
            $error("oddr_lane: DDR_CLK_EDGE must be OPPOSITE_EDGE or SAME_EDGE");
        end

        if (SAME_MODE) begin : g_same
            logic hold_r = INIT;

            // D2 captured alongside D1 on the rising edge, replayed on the fall.
            always_ff @(posedge C or posedge arst_s) begin
                if (arst_s) begin
                    hold_r <= INIT;
                end else if (CE) begin
                    hold_r <= D2;
                end else begin
                    hold_r <= hold_r;
                end
            end

            assign fall_d_s = hold_r;
        end else begin : g_opp
            assign fall_d_s = D2;
        end
    endgenerate

    // Rising half; with CE low it copies the falling flop so the muxed Q stays put.
    always_ff @(posedge C or posedge arst_s) begin
        if (arst_s) begin
            pos_r <= INIT;
        end else if (CE) begin
            pos_r <= D1;
        end else begin
            pos_r <= neg_r;
        end
    end

    // Falling half; mirror of the rising flop for the CE-low freeze.
    always_ff @(negedge C or posedge arst_s) begin
        if (arst_s) begin
            neg_r <= INIT;
        end else if (CE) begin
            neg_r <= fall_d_s;
        end else begin
            neg_r <= pos_r;
        end
    end

    assign Q = C ? pos_r : neg_r;

endmodule

// File: rtl/oddr.sv
// WIDTH-lane DDR output register: fans shared controls out to independent lanes.
module oddr
    import oddr_pkg::*;
#(
    parameter string DDR_CLK_EDGE = EDGE_OPPOSITE,
    parameter bit    INIT         = 1'b0,
    parameter int    WIDTH        = 1
) (
    input  logic             C,
    input  logic             R,
    input  logic             S,
    input  logic             CE,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    output logic [WIDTH-1:0] Q
);

    genvar lane;
    generate
        for (lane = 0; lane < WIDTH; lane = lane + 1) begin : g_lane
            oddr_lane #(
                .DDR_CLK_EDGE (DDR_CLK_EDGE),
                .INIT         (INIT)
            ) u_lane (
                .C  (C),
                .R  (R),
                .S  (S),
                .CE (CE),
                .D1 (D1[lane]),
                .D2 (D2[lane]),
                .Q  (Q[lane])
            );
        end
    endgenerate

endmodule

// File: tb/tb_oddr.sv
// Randomised self-checking bench for oddr: three instances (opposite-edge,
// same-edge, set/INIT=1) compared against an edge-event reference model.
module tb_oddr;

    logic       C  = 1'b0;
    logic       R  = 1'b1;
    logic       S  = 1'b0;
    logic       CE = 1'b1;
    logic       R1 = 1'b1;
    logic       S1 = 1'b0;
    logic [5:0] D1 = 6'h15;
    logic [5:0] D2 = 6'h2A;
    logic [5:0] q_opp;
    logic [5:0] q_same;
    logic       q_set;

    int checks = 0;
    int errors = 0;

    // reference model: what each output should show right now
    logic [5:0] m_opp  = 6'h00;
    logic [5:0] m_same = 6'h00;
    logic [5:0] m_hold = 6'h00;
    logic       m_set  = 1'b1;

    oddr #(.DDR_CLK_EDGE("OPPOSITE_EDGE"), .INIT(1'b0), .WIDTH(6)) u_opp (
        .C(C), .R(R), .S(S), .CE(CE), .D1(D1), .D2(D2), .Q(q_opp)
    );

    oddr #(.DDR_CLK_EDGE("SAME_EDGE"), .INIT(1'b0), .WIDTH(6)) u_same (
        .C(C), .R(R), .S(S), .CE(CE), .D1(D1), .D2(D2), .Q(q_same)
    );

    oddr #(.DDR_CLK_EDGE("OPPOSITE_EDGE"), .INIT(1'b1), .WIDTH(1)) u_set (
        .C(C), .R(R1), .S(S1), .CE(CE), .D1(D1[0:0]), .D2(D2[0:0]), .Q(q_set)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".opp"},  {2'b00, q_opp},  {2'b00, m_opp});
        check({tag, ".same"}, {2'b00, q_same}, {2'b00, m_same});
        check({tag, ".set"},  {7'b0, q_set},   {7'b0, m_set});
    endtask

    task automatic model_async();
        if (R || S) begin
            m_opp  = 6'h00;
            m_same = 6'h00;
            m_hold = 6'h00;
        end
        if (R1 || S1) m_set = 1'b1;
    endtask

    task automatic model_edge(input logic rising);
        if (rising) begin
            if (!(R || S) && CE) begin
                m_opp  = D1;
                m_same = D1;
                m_hold = D2;
            end
            if (!(R1 || S1) && CE) m_set = D1[0];
        end else begin
            if (!(R || S) && CE) begin
                m_opp  = D2;
                m_same = m_hold;
            end
            if (!(R1 || S1) && CE) m_set = D2[0];
        end
        model_async();
    endtask

    // one half-period: inputs settle, edge, model update, sample 1 later
    task automatic half(input logic lvl, input string tag);
        #2;
        C = lvl;
        model_edge(lvl);
        #1;
        check_all(tag);
        #2;
    endtask

    task automatic pulse_reset(input string tag);
        R = 1'b1;
        #1;
        model_async();
        check_all(tag);
        R = 1'b0;
        #1;
    endtask

    initial begin
        #1;
        model_async();
        check_all("reset_t0");

        // reset held with clock running and data present
        for (int i = 0; i < 3; i++) begin
            half(1'b1, "rst_hold_hi");
            half(1'b0, "rst_hold_lo");
        end
        R  = 1'b0;
        R1 = 1'b0;
        half(1'b1, "first_rise");
        pulse_reset("rst_mid_high");
        half(1'b0, "after_rst_fall");

        // opposite-edge constant pattern
        D1 = 6'h0A;
        D2 = 6'h35;
        for (int i = 0; i < 4; i++) begin
            half(1'b1, "const_hi");
            half(1'b0, "const_lo");
        end

        // counting pattern, exercises same-edge hold
        for (int k = 0; k < 8; k++) begin
            D1 = 6'(k);
            D2 = 6'(63 - k);
            half(1'b1, "count_hi");
            half(1'b0, "count_lo");
        end

        // clock enable low with changing data
        CE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            D1 = 6'($urandom);
            D2 = 6'($urandom);
            half(1'b1, "ce0_hi");
            half(1'b0, "ce0_lo");
        end
        CE = 1'b1;
        D1 = 6'h2C;
        D2 = 6'h13;
        half(1'b1, "ce_resume_hi");
        half(1'b0, "ce_resume_lo");

        // randomised traffic with sporadic CE gaps and reset pulses
        for (int i = 0; i < 60; i++) begin
            D1 = 6'($urandom);
            D2 = 6'($urandom);
            CE = ($urandom_range(0, 3) != 0);
            half(1'b1, "rand_hi");
            if ($urandom_range(0, 9) == 0) pulse_reset("rand_rst_hi");
            if ($urandom_range(0, 3) == 0) D2 = 6'($urandom);
            half(1'b0, "rand_lo");
            if ($urandom_range(0, 9) == 0) pulse_reset("rand_rst_lo");
        end
        CE = 1'b1;

        // reset between rise and fall discards the pending same-edge word
        D1 = 6'h11;
        D2 = 6'h22;
        half(1'b1, "hold_rise");
        pulse_reset("hold_rst");
        half(1'b0, "hold_cleared_fall");
        D1 = 6'h2B;
        D2 = 6'h14;
        half(1'b1, "resume_rise");
        half(1'b0, "resume_fall");

        // set on the INIT=1 instance, alone and together with reset
        D1 = 6'h00;
        D2 = 6'h00;
        half(1'b1, "set_pre_hi");
        half(1'b0, "set_pre_lo");
        S1 = 1'b1;
        #1;
        model_async();
        check_all("set_async");
        R1 = 1'b1;
        #1;
        model_async();
        check_all("set_and_reset");
        R1 = 1'b0;
        #1;
        check_all("set_only_again");
        half(1'b1, "set_held_hi");
        S1 = 1'b0;
        half(1'b0, "set_release_lo");
        half(1'b1, "set_release_hi");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
